// File: rtl/bmu_pkg.sv
// Shared definitions for the BMU/FPU bit-manipulation blocks.
package bmu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } lzcstate_t;

    // Count width able to hold 0..w inclusive.
    function automatic int lzc_cw(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/chunk_lzc.sv
// Priority encoder: leading-zero count of a nonzero CHUNK-bit slice.
module chunk_lzc #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0]         slice,
    output logic [$clog2(CHUNK)-1:0] lz
);

    localparam int LW = $clog2(CHUNK);

    // Scan LSB to MSB so the highest set bit wins; an all-zero slice yields 0.
    always_comb begin
        lz = '0;
        for (int i = 0; i < CHUNK; i++) begin
            lz = slice[i] ? LW'(CHUNK - 1 - i) : lz;
        end
    end

endmodule

// File: rtl/lzc_normalizer.sv
// Multi-cycle leading-zero counter and left-normalizer, CHUNK bits per cycle.
module lzc_normalizer
    import bmu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            a,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(WIDTH+1)-1:0]  count,
    output logic [WIDTH-1:0]            norm,
    output logic                        zero
);

    localparam int CW  = lzc_cw(WIDTH);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LW  = $clog2(CHUNK);

    lzcstate_t        state_r;
    lzcstate_t        state_nxt_s;
    logic [WIDTH-1:0] sh_r;
    logic [CW-1:0]    cnt_r;
    logic [IW-1:0]    iter_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [CHUNK-1:0] top_s;
    logic [LW-1:0]    lz_s;
    logic             top_zero_s;
    logic             last_s;
    logic [WIDTH-1:0] sh_norm_s;
    logic [CW-1:0]    cnt_lz_s;

    assign top_s      = sh_r[WIDTH-1 -: CHUNK];
    assign top_zero_s = (top_s == '0);
    assign last_s     = (iter_r == IW'(NCH - 1));
    assign sh_norm_s  = sh_r << lz_s;
    assign cnt_lz_s   = cnt_r + CW'(lz_s);

    chunk_lzc #(.CHUNK(CHUNK)) u_chunk_lzc (
        .slice (top_s),
        .lz    (lz_s)
    );

    // Next-state selection; flush overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = in_valid ? SCAN : IDLE;
                SCAN:    state_nxt_s = (!top_zero_s || last_s) ? DONE : SCAN;
                DONE:    state_nxt_s = out_ready ? IDLE : DONE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State, handshake flags, scan datapath and the held result registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            sh_r        <= '0;
            cnt_r       <= '0;
            iter_r      <= '0;
            count       <= '0;
            norm        <= '0;
            zero        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
            if (!flush) begin
                case (state_r)
                    IDLE: begin
                        if (in_valid) begin
                            sh_r   <= a;
                            cnt_r  <= '0;
                            iter_r <= '0;
                        end
                    end
                    SCAN: begin
                        if (top_zero_s) begin
                            sh_r  <= sh_r << CHUNK;
                            cnt_r <= cnt_r + CW'(CHUNK);
                            if (last_s) begin
                                count <= cnt_r + CW'(CHUNK);
                                norm  <= '0;
                                zero  <= 1'b1;
                            end else begin
                                iter_r <= iter_r + IW'(1);
                            end
                        end else begin
                            // Leading one sits in this chunk: finish in one step.
                            sh_r  <= sh_norm_s;
                            cnt_r <= cnt_lz_s;
                            count <= cnt_lz_s;
                            norm  <= sh_norm_s;
                            zero  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;

endmodule
